// File: rtl/serial_xnor_cmp.sv
// Bit-serial word comparator: folds LSB-first per-bit XNOR results into
// word equality, mismatch count and lowest mismatching bit index.
module serial_xnor_cmp #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic          a,
    input  logic          b,
    output logic          busy,
    output logic          done,
    output logic          eq,
    output logic [CW-1:0] miss_cnt,
    output logic [CW-1:0] first_miss
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] NO_MISS  = CW'(WIDTH);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] idx;
    logic          start_ok_c;
    logic          take_bit_c;
    logic          bit_eq_c;

    assign start_ok_c = (state == IDLE) && start;
    assign take_bit_c = (state == SHIFT) && in_valid;
    assign bit_eq_c   = a ~^ b;

    // State register; busy/done are flopped decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (in_valid && (idx == LAST_IDX)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result accumulation; results hold outside SHIFT until the next start.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            eq         <= 1'b0;
            miss_cnt   <= '0;
            first_miss <= '0;
        end else if (start_ok_c) begin
            idx        <= '0;
            eq         <= 1'b1;
            miss_cnt   <= '0;
            first_miss <= NO_MISS;
        end else if (take_bit_c) begin
            eq  <= eq & bit_eq_c;
            idx <= (idx == LAST_IDX) ? '0 : idx + CW'(1);
            if (!bit_eq_c) begin
                miss_cnt <= miss_cnt + CW'(1);
                if (first_miss == NO_MISS) first_miss <= idx;
            end
        end
    end

endmodule

// File: tb/tb_serial_xnor_cmp.sv
// Scoreboard bench for serial_xnor_cmp: driver queues word-level expectations,
// a negedge monitor checks each done pulse against them.
module tb_serial_xnor_cmp;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          a = 1'b0;
    logic          b = 1'b0;
    logic          busy;
    logic          done;
    logic          eq;
    logic [CW-1:0] miss_cnt;
    logic [CW-1:0] first_miss;

    typedef struct {
        int eq;
        int miss;
        int first;
        int done_cyc;
        int busy_n;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   busy_cnt = 0;
    int   errors = 0;
    int   checks = 0;
    bit   prev_done = 1'b0;

    serial_xnor_cmp #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .eq         (eq),
        .miss_cnt   (miss_cnt),
        .first_miss (first_miss)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Word-level reference: equality, popcount of differences, lowest differing bit.
    function automatic exp_t model(input logic [W-1:0] wa, input logic [W-1:0] wb);
        exp_t e;
        logic [W-1:0] diff;
        diff    = wa ^ wb;
        e.eq    = (wa == wb) ? 1 : 0;
        e.miss  = $countones(diff);
        e.first = W;
        for (int i = W - 1; i >= 0; i--)
            if (diff[i]) e.first = i;
        e.done_cyc = 0;
        e.busy_n   = 0;
        return e;
    endfunction

    // One full compare; returns at the first IDLE negedge after done.
    task automatic run_cmp(input logic [W-1:0] wa, input logic [W-1:0] wb,
                           input logic [W-1:0] stalls, input bit extra);
        exp_t e;
        int   ns;
        ns = $countones(stalls);
        e  = model(wa, wb);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start      = 1'b0;
        e.done_cyc = cyc + W + ns;
        e.busy_n   = W + ns;
        q.push_back(e);
        for (int i = 0; i < W; i++) begin
            if (stalls[i]) begin
                in_valid = 1'b0;
                a = 1'($urandom);
                b = 1'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            a        = wa[i];
            b        = wb[i];
            start    = extra && (i == 3);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = extra;
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_done", int'(busy), 0);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (done) begin
            chk("done_single_cycle", int'(prev_done), 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending compare (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("eq", int'(eq), e.eq);
                chk("miss_cnt", int'(miss_cnt), e.miss);
                chk("first_miss", int'(first_miss), e.first);
                chk("done_latency", cyc, e.done_cyc);
                chk("busy_cycles", busy_cnt, e.busy_n);
                chk("busy_in_done", int'(busy), 0);
            end
            busy_cnt = 0;
        end
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] rs;

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_eq", int'(eq), 0);
        chk("rst_miss_cnt", int'(miss_cnt), 0);
        chk("rst_first_miss", int'(first_miss), 0);
        reset = 1'b0;
        @(negedge clk);

        run_cmp(8'hA5, 8'hA5, 8'h00, 1'b0);
        run_cmp(8'hA5, 8'hA4, 8'h00, 1'b0);
        run_cmp(8'h00, 8'hFF, 8'h38, 1'b0);
        run_cmp(8'h0F, 8'h8F, 8'h00, 1'b1);

        // Abort mid-stream with reset: results clear and no done pulse.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = 1'b0;
            b = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_eq", int'(eq), 0);
        chk("abort_miss_cnt", int'(miss_cnt), 0);
        chk("abort_first_miss", int'(first_miss), 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        busy_cnt = 0;
        @(negedge clk);
        run_cmp(8'hA5, 8'hA5, 8'h00, 1'b0);

        // Reset and start on the same edge: reset wins.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_beats_start", int'(busy), 0);
        @(negedge clk);
        chk("rst_beats_start_hold", int'(busy), 0);

        // Back-to-back: second result must not inherit the first.
        run_cmp(8'h00, 8'hFF, 8'h00, 1'b0);
        run_cmp(8'h3C, 8'h3C, 8'h00, 1'b0);
        run_cmp(8'h80, 8'h00, 8'h00, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            rs = W'($urandom) & W'($urandom) & W'($urandom);
            run_cmp(ra, rb, rs, 1'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        chk("all_results_seen", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
